// File: rtl/axis_loopback_pkg.sv
// Shared types and constants for the multi-channel AXI-Stream loopback.
package axis_loopback_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FINISH = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam int STATS_WIDTH = 32;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_loopback_fifo.sv
// Single-clock FIFO with a registered head-of-queue output and occupancy count.
module axis_loopback_fifo
  import axis_loopback_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop;

  assign pop  = rd_valid && rd_ready;
  assign full = (level == LW'(DEPTH));

  // The output register mirrors mem[rd_ptr]; a push into an otherwise empty
  // queue has to bypass the array because the write lands on this same edge.
  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(pop);
    level_nxt  = level + LW'(push) - LW'(pop);
    head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      rd_valid <= (level_nxt != '0);
      if (level_nxt != '0) rd_data <= head_nxt;
    end
  end

endmodule

// File: rtl/axis_loopback_mc.sv
// CH_NB-channel buffered AXI-Stream loopback with packet-safe halt per channel.
// Optional per-channel beat/packet counters when AXIS_LOOPBACK_STATS_EN is defined.
module axis_loopback_mc
  import axis_loopback_pkg::*;
#(
  parameter int CH_NB      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int LW = level_width(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CH_NB*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CH_NB-1:0]            s_axis_tlast,
  input  logic [CH_NB-1:0]            s_axis_tvalid,
  output logic [CH_NB-1:0]            s_axis_tready,
  output logic [CH_NB*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CH_NB-1:0]            m_axis_tlast,
  output logic [CH_NB-1:0]            m_axis_tvalid,
  input  logic [CH_NB-1:0]            m_axis_tready,
  input  logic [CH_NB-1:0]            cfg_halt,
  output logic [CH_NB-1:0]            sts_halted,
`ifdef AXIS_LOOPBACK_STATS_EN
  output logic [CH_NB*LW-1:0]          sts_level,
  output logic [CH_NB*STATS_WIDTH-1:0] sts_beats,
  output logic [CH_NB*STATS_WIDTH-1:0] sts_pkts
`else
  output logic [CH_NB*LW-1:0]          sts_level
`endif
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  for (genvar i = 0; i < CH_NB; i++) begin : g_ch
    state_t              state;
    logic                mid;
    logic                up;
    logic                full;
    logic                ready;
    logic                push;
    logic                mid_nxt;
    logic                last_in;
    logic                rd_valid;
    logic [DATA_WIDTH:0] rd_data;
    logic [LW-1:0]       level;

    assign last_in = s_axis_tlast[i];
    // up keeps tready low through reset and releases it one cycle later.
    assign ready   = up && (state != HALT) && !full;
    assign push    = s_axis_tvalid[i] && ready;
    assign mid_nxt = push ? !last_in : mid;

    // Halt decisions use the post-beat packet position so a beat accepted in
    // the same cycle as the request is never orphaned.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state <= RUN;
        mid   <= 1'b0;
        up    <= 1'b0;
      end else begin
        up  <= 1'b1;
        mid <= mid_nxt;
        case (state)
          RUN:     if (cfg_halt[i]) state <= mid_nxt ? FINISH : HALT;
          FINISH: begin
            if (!cfg_halt[i])          state <= RUN;
            else if (push && last_in)  state <= HALT;
          end
          HALT:    if (!cfg_halt[i]) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end

    axis_loopback_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .wr_data  ({last_in, s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]}),
      .full     (full),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (m_axis_tready[i]),
      .level    (level)
    );

    assign s_axis_tready[i]                          = ready;
    assign m_axis_tvalid[i]                          = rd_valid;
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]  = rd_data[DATA_WIDTH-1:0];
    assign m_axis_tlast[i]                           = rd_data[DATA_WIDTH];
    assign sts_halted[i]                             = (state == HALT);
    assign sts_level[i*LW +: LW]                     = level;

`ifdef AXIS_LOOPBACK_STATS_EN
    logic [STATS_WIDTH-1:0] beats;
    logic [STATS_WIDTH-1:0] pkts;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        beats <= '0;
        pkts  <= '0;
      end else if (push) begin
        beats <= beats + STATS_WIDTH'(1);
        if (last_in) pkts <= pkts + STATS_WIDTH'(1);
      end
    end

    assign sts_beats[i*STATS_WIDTH +: STATS_WIDTH] = beats;
    assign sts_pkts[i*STATS_WIDTH +: STATS_WIDTH]  = pkts;
`endif
  end

endmodule
